// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states, flag bit positions and iteration count shared by the ALU files.
package alu_pkg;
  localparam int ITERS = 16;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_NOT = 4'd5, OP_LSL = 4'd6, OP_LSR = 4'd7,
                         OP_MUL = 4'd8, OP_DIV = 4'd9, OP_MOD = 4'd10;
  localparam int FLAG_Z = 3, FLAG_N = 2, FLAG_C = 1, FLAG_V = 0;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_DONE} state_t;
  function automatic logic is_iter(input logic [3:0] op);
    return op == OP_MUL || op == OP_DIV || op == OP_MOD;
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider.
// The first step runs on the start edge, so o_done rises after ITERS edges.
module alu_muldiv_iter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_mul,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_done,
  output logic [31:0] o_p
);
  logic        r_run, r_mul;
  logic [4:0]  r_cnt;
  logic [15:0] r_op;
  logic [31:0] r_p;
  logic        w_mul, w_ge;
  logic [15:0] w_op, w_d;
  logic [16:0] w_s, w_sh;
  logic [31:0] w_p, w_mn, w_dn;
  assign w_mul = i_start ? i_mul : r_mul;
  assign w_op  = i_start ? (i_mul ? i_a : i_b) : r_op;
  assign w_p   = i_start ? {16'h0, i_mul ? i_b : i_a} : r_p;
  // Multiply: {hi,lo} holds partial product over the remaining multiplier bits.
  assign w_s   = {1'b0, w_p[31:16]} + (w_p[0] ? {1'b0, w_op} : 17'd0);
  assign w_mn  = {w_s, w_p[15:1]};
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign w_sh  = {w_p[31:16], w_p[15]};
  assign w_ge  = w_sh >= {1'b0, w_op};
  assign w_d   = w_sh[15:0] - w_op;
  assign w_dn  = {w_ge ? w_d : w_sh[15:0], w_p[14:0], w_ge};
  assign o_done = r_run && r_cnt == 5'(ITERS);
  assign o_p    = r_p;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run <= 1'b0;
      r_mul <= 1'b0;
      r_cnt <= 5'd0;
      r_op  <= 16'h0;
      r_p   <= 32'h0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_mul <= w_mul;
      r_cnt <= 5'd1;
      r_op  <= w_op;
      r_p   <= w_mul ? w_mn : w_dn;
    end else if (r_run) begin
      r_run <= r_cnt != 5'(ITERS);
      r_cnt <= r_cnt == 5'(ITERS) ? 5'd0 : r_cnt + 5'd1;
      r_p   <= r_cnt == 5'(ITERS) ? r_p : (r_mul ? w_mn : w_dn);
    end
  end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: start/done ALU with single-cycle ops, iterative MUL/DIV/MOD and {Z,N,C,V} flags.
module alu_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [15:0] operand_acc,
  input  logic [15:0] operand_reg,
  output logic [15:0] result,
  output logic        save_result,
  output logic        busy,
  output logic        done,
  output logic [3:0]  flags
);
  state_t      r_state;
  logic [3:0]  r_op;
  logic [15:0] r_a, r_b;
  logic        w_iter, w_md_done, w_fin, w_legal, w_c, w_v;
  logic [15:0] w_res;
  logic [3:0]  w_flags;
  logic [16:0] w_add, w_sub, w_sl, w_sr;
  logic [31:0] w_p;
  assign w_iter = is_iter(r_op) && r_b != 16'h0;
  assign w_fin  = (r_state == S_EXEC && !w_iter) || (r_state == S_ITER && w_md_done);
  assign busy   = r_state != S_IDLE;
  alu_muldiv_iter u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_state == S_EXEC && w_iter),
    .i_mul   (r_op == OP_MUL),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_done  (w_md_done),
    .o_p     (w_p)
  );
  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};
  // The extra bit of each shift catches the last bit shifted out.
  assign w_sl  = {1'b0, r_a} << r_b[3:0];
  assign w_sr  = {r_a, 1'b0} >> r_b[3:0];
  always_comb begin
    w_res   = 16'h0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_legal = 1'b1;
    w_flags = 4'h0;
    case (r_op)
      OP_ADD: begin
        w_res = w_add[15:0];
        w_c   = w_add[16];
        w_v   = (r_a[15] == r_b[15]) && (w_add[15] != r_a[15]);
      end
      OP_SUB: begin
        w_res = w_sub[15:0];
        w_c   = w_sub[16];
        w_v   = (r_a[15] != r_b[15]) && (w_sub[15] != r_a[15]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOT: w_res = ~r_a;
      OP_LSL: begin
        w_res = w_sl[15:0];
        w_c   = w_sl[16];
      end
      OP_LSR: begin
        w_res = w_sr[16:1];
        w_c   = w_sr[0];
      end
      OP_MUL: begin
        w_res = w_iter ? w_p[15:0] : 16'h0;
        w_v   = w_iter && |w_p[31:16];
      end
      OP_DIV: begin
        w_res = w_iter ? w_p[15:0] : 16'hFFFF;
        w_v   = !w_iter;
      end
      OP_MOD: begin
        w_res = w_iter ? w_p[31:16] : r_a;
        w_v   = !w_iter;
      end
      default: w_legal = 1'b0;
    endcase
    w_flags[FLAG_Z] = w_res == 16'h0;
    w_flags[FLAG_N] = w_res[15];
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_V] = w_v;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= 4'h0;
      r_a         <= 16'h0;
      r_b         <= 16'h0;
      result      <= 16'h0;
      flags       <= 4'h0;
      done        <= 1'b0;
      save_result <= 1'b0;
    end else begin
      done        <= 1'b0;
      save_result <= 1'b0;
      if (w_fin) begin
        r_state     <= S_DONE;
        done        <= 1'b1;
        save_result <= w_legal;
        result      <= w_legal ? w_res : result;
        flags       <= w_legal ? w_flags : flags;
      end else if (r_state == S_IDLE && start) begin
        r_state <= S_EXEC;
        r_op    <= opcode;
        r_a     <= operand_acc;
        r_b     <= operand_reg;
      end else if (r_state == S_EXEC) begin
        r_state <= S_ITER;
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomized checks of alu_unit against a cycle-level behavioural model.
module tb_alu_unit;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic [15:0] operand_acc = 16'h0, operand_reg = 16'h0;
  logic [15:0] result;
  logic        save_result, busy, done;
  logic [3:0]  flags;

  alu_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .operand_acc (operand_acc),
    .operand_reg (operand_reg),
    .result      (result),
    .save_result (save_result),
    .busy        (busy),
    .done        (done),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  bit          m_act = 0, m_done = 0, m_save = 0, m_pl = 0;
  logic [15:0] m_res = 16'h0, m_pr = 16'h0;
  logic [3:0]  m_flags = 4'h0, m_pf = 4'h0;
  int          m_end = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic [3:0] f, output bit ok);
    longint p;
    int sa, sb, sr, n;
    bit c, v;
    sa = $signed(a); sb = $signed(b); n = int'(b[3:0]);
    c = 0; v = 0; ok = 1; r = 16'h0;
    case (op)
      4'd0: begin p = longint'(a) + longint'(b); r = p[15:0]; c = p > 65535; sr = sa + sb; v = sr > 32767 || sr < -32768; end
      4'd1: begin r = a - b; c = a < b; sr = sa - sb; v = sr > 32767 || sr < -32768; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = a << n; c = (n == 0) ? 1'b0 : a[16-n]; end
      4'd7: begin r = a >> n; c = (n == 0) ? 1'b0 : a[n-1]; end
      4'd8: begin p = longint'(a) * longint'(b); r = p[15:0]; v = p > 65535; end
      4'd9: begin r = (b == 0) ? 16'hFFFF : a / b; v = b == 0; end
      4'd10: begin r = (b == 0) ? a : a % b; v = b == 0; end
      default: ok = 0;
    endcase
    f = {r == 16'h0, r[15], c, v};
  endfunction

  // Model: what every output must be after each rising edge.
  always @(posedge clk) begin : model
    bit was;
    cyc++;
    was = m_act;
    m_done = 0;
    m_save = 0;
    if (rst) begin
      m_act = 0; m_res = 16'h0; m_flags = 4'h0;
    end else begin
      if (m_act && cyc == m_end + 1) m_act = 0;
      if (m_act && cyc == m_end) begin
        m_done = 1;
        m_save = m_pl;
        if (m_pl) begin m_res = m_pr; m_flags = m_pf; end
      end
      if (!was && start) begin
        ref_op(opcode, operand_acc, operand_reg, m_pr, m_pf, m_pl);
        m_act = 1;
        m_end = cyc + ((opcode inside {4'd8, 4'd9, 4'd10} && operand_reg != 16'h0) ? 17 : 1);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("result", result, m_res);
      chk("flags", flags, m_flags);
      chk("done", done, m_done);
      chk("save_result", save_result, m_save);
      chk("busy", busy, m_act);
    end
  end

  task automatic run_op(input string nm, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [3:0] ef, input int lat, input bit sv);
    int k, n;
    @(negedge clk);
    start = 1; opcode = op; operand_acc = a; operand_reg = b;
    @(negedge clk);
    start = 0;
    k = cyc;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, cyc - k + 1, lat);
    chk({nm, "_result"}, result, er);
    chk({nm, "_flags"}, flags, ef);
    chk({nm, "_save"}, save_result, sv);
    chk({nm, "_busy_at_done"}, busy, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_abort();
    int k;
    @(negedge clk);
    start = 1; opcode = 4'd8; operand_acc = 16'h0300; operand_reg = 16'h0100;
    @(negedge clk);
    start = 0;
    k = cyc;
    while (cyc < k + 4) @(negedge clk);
    start = 1; opcode = 4'd0;
    @(negedge clk);
    start = 0;
    while (cyc < k + 9) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_result", result, 0);
    chk("abort_flags", flags, 0);
    chk("abort_done", done, 0);
    chk("abort_save", save_result, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [15:0] r;
    logic [3:0]  f;
    bit          ok;
    ref_op(4'd0, 16'h7FFF, 16'h0001, r, f, ok);
    chk("model_add", {r, f}, {16'h8000, 4'b0101});
    ref_op(4'd6, 16'h8001, 16'h0001, r, f, ok);
    chk("model_lsl", {r, f}, {16'h0002, 4'b0010});
    ref_op(4'd7, 16'h0003, 16'h0001, r, f, ok);
    chk("model_lsr", {r, f}, {16'h0001, 4'b0010});
    ref_op(4'd10, 16'd100, 16'd7, r, f, ok);
    chk("model_mod", {r, f}, {16'd2, 4'b0000});
    repeat (3) @(negedge clk);
    rst = 0;
    run_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 2, 1);
    run_op("sub_borrow", 4'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 2, 1);
    run_op("mul_hi", 4'd8, 16'h0300, 16'h0100, 16'h0000, 4'b1001, 18, 1);
    run_op("div", 4'd9, 16'd100, 16'd7, 16'd14, 4'b0000, 18, 1);
    run_op("mod", 4'd10, 16'd100, 16'd7, 16'd2, 4'b0000, 18, 1);
    run_op("div0", 4'd9, 16'd100, 16'd0, 16'hFFFF, 4'b0101, 2, 1);
    run_op("illegal", 4'hF, 16'h1234, 16'h5678, 16'hFFFF, 4'b0101, 2, 0);
    run_op("lsl_by0", 4'd6, 16'h8001, 16'h0010, 16'h8001, 4'b0100, 2, 1);
    reset_abort();
    repeat (3000) begin
      @(negedge clk);
      start = $urandom_range(0, 3) == 0;
      opcode = 4'($urandom_range(0, 15));
      operand_acc = 16'($urandom);
      case ($urandom_range(0, 7))
        0: operand_reg = 16'h0;
        1: operand_reg = 16'($urandom_range(0, 17));
        default: operand_reg = 16'($urandom);
      endcase
      rst = $urandom_range(0, 399) == 0;
    end
    @(negedge clk);
    rst = 0;
    start = 0;
    repeat (25) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset: clk and rst.
REQ-002 The port clk SHALL be an input, 1 bit wide, carrying the clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, carrying the synchronous active-high reset.
REQ-004 The port start SHALL be an input, 1 bit wide, and is a one-cycle request to launch an operation.
REQ-005 The port opcode SHALL be an input, 4 bits wide, selecting the operation (see REQ-012).
REQ-006 The port operand_acc SHALL be an input, 16 bits wide, carrying operand A (the accumulator read value).
REQ-007 The port operand_reg SHALL be an input, 16 bits wide, carrying operand B (the X/Y read value).
REQ-008 The port result SHALL be an output, 16 bits wide, carrying the registered result (the accumulator write data).
REQ-009 The port save_result SHALL be an output, 1 bit wide, and is a one-cycle accumulator write strobe.
REQ-010 The port busy SHALL be an output, 1 bit wide, and is high from the start acceptance until done.
REQ-011 The ports done (output, 1 bit) and flags (output, 4 bits) SHALL be provided: done is a one-cycle completion pulse, and flags = {Z,N,C,V}.

Function
REQ-012 The opcode encoding SHALL be: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 LSL A by B[3:0], 7 LSR A by B[3:0], 8 MUL (low 16 bits of A*B, unsigned), 9 DIV (A/B unsigned), 10 MOD (A%B unsigned); all other values are illegal.
REQ-013 A start request SHALL be accepted only in IDLE; operands and opcode are latched on the acceptance edge, and start is ignored while busy=1.
REQ-014 The FSM SHALL have the states IDLE, EXEC, ITER and DONE, with these transitions:
- IDLE->EXEC on start.
- EXEC->ITER for MUL/DIV/MOD with B!=0.
- Otherwise EXEC->DONE.
- ITER->DONE after exactly 16 iterations.
- DONE->IDLE unconditionally.
REQ-015 Latency SHALL be measured from the start acceptance edge k: single-cycle ops assert done at k+2, and MUL/DIV/MOD with B!=0 assert done at k+18.
REQ-016 result, flags, done and save_result SHALL update together in DONE; result and flags then hold until the next completion.
REQ-017 save_result SHALL equal done for legal opcodes; an illegal opcode SHALL pulse done with save_result=0 and leave result and flags unchanged.
REQ-018 The flags SHALL be computed as follows:
- Z = (result==0) and N = result[15] for all legal ops.
- ADD: C = carry out, V = signed overflow.
- SUB: C = borrow (A<B unsigned), V = signed overflow.
- Logical ops: C = V = 0.
- Shifts: C = last bit shifted out, or 0 if the amount is 0, and V = 0.
- MUL: C = 0, V = 1 if the upper 16 bits of the product are nonzero.
- DIV/MOD: C = 0, V = 0.
REQ-019 Division by zero SHALL skip ITER: DIV yields 16'hFFFF, MOD yields A, V=1, and latency is 2 cycles.
REQ-020 MUL SHALL use a shift-add algorithm and DIV/MOD SHALL use a restoring algorithm, one bit per cycle, on latched operands; input changes during ITER have no effect.
REQ-021 busy SHALL be high in EXEC, ITER and DONE, and low in IDLE.
REQ-022 All arithmetic SHALL be 16-bit unsigned, with a 17-bit internal add/sub and a 32-bit internal product.

Reset
REQ-023 When rst=1 at a rising edge, the FSM SHALL enter IDLE and result, flags, done, save_result, busy and the iteration count SHALL be zero.
REQ-024 A reset during EXEC or ITER SHALL abort the operation with no done or save_result pulse.
REQ-025 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-026 A shared package alu_pkg SHALL hold the opcode constants, the FSM state encoding, the flag bit indices and the iteration count (16).
REQ-027 The iterative multiply/divide datapath SHALL be one sub-module, alu_muldiv_iter, with a start/done interface; alu_unit holds the FSM, single-cycle ops and output registers.

Verification
REQ-028 ADD with A=16'h7FFF, B=16'h0001 -> at k+2, result=16'h8000, flags Z0 N1 C0 V1, and save_result pulses once.
REQ-029 SUB with A=16'h0003, B=16'h0005 -> result=16'hFFFE, C=1, N=1, latency 2.
REQ-030 MUL with A=16'h0300, B=16'h0100 -> at k+18, result=16'h0000, Z=1, V=1, and busy is high for cycles k+1 to k+18.
REQ-031 DIV with A=16'd100, B=16'd7 -> 16'd14, and MOD with the same operands -> 16'd2; DIV with B=0 -> 16'hFFFF, V=1 at k+2.
REQ-032 Start MUL, then assert start with opcode ADD at k+5 and rst=1 at k+10 -> the second start is ignored, no done occurs, and all outputs are 0 at k+11.
REQ-033 Opcode 4'hF -> done pulses at k+2 with save_result=0, and result/flags retain their prior values.
